// File: rtl/apb_slave.sv
// apb_slave: APB3 completer with a word-indexed register file, programmable wait states
// and an error response for out-of-range indices.
module apb_slave #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   regs [DEPTH];
    logic [3:0]    cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx, sel_idx;
    logic          wr, wr_nx, ok, ok_nx, sel_wr, sel_ok, in_range, fin, we;
    logic          pready_nx, pslverr_nx;
    logic [31:0]   prdata_nx;

    assign in_range = (paddr >> IW) == 32'd0;
    // With zero wait states the response is built on the setup edge, before anything is latched
    assign sel_idx  = (state == IDLE) ? paddr[IW-1:0] : idx;
    assign sel_wr   = (state == IDLE) ? pwrite : wr;
    assign sel_ok   = (state == IDLE) ? in_range : ok;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        wr_nx      = wr;
        ok_nx      = ok;
        fin        = 1'b0;
        we         = 1'b0;
        pready_nx  = pready;
        pslverr_nx = pslverr;
        prdata_nx  = prdata;
        case (state)
            IDLE: if (psel && !penable) begin
                wr_nx    = pwrite;
                idx_nx   = paddr[IW-1:0];
                ok_nx    = in_range;
                cnt_nx   = 4'(WAIT_CYCLES);
                fin      = (WAIT_CYCLES == 0);
                state_nx = fin ? DONE : WAIT;
            end
            WAIT: if (!psel) begin
                state_nx = IDLE;
            end else if (penable) begin
                cnt_nx   = cnt - 4'd1;
                fin      = (cnt == 4'd1);
                state_nx = fin ? DONE : WAIT;
            end
            DONE: if (!psel || penable) begin
                we         = psel && wr && ok;
                state_nx   = IDLE;
                pready_nx  = 1'b0;
                pslverr_nx = 1'b0;
                prdata_nx  = '0;
            end
            default: state_nx = IDLE;
        endcase
        if (fin) begin
            pready_nx  = 1'b1;
            pslverr_nx = !sel_ok;
            prdata_nx  = (!sel_wr && sel_ok) ? regs[sel_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            wr      <= 1'b0;
            ok      <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            wr      <= wr_nx;
            ok      <= ok_nx;
            pready  <= pready_nx;
            pslverr <= pslverr_nx;
            prdata  <= prdata_nx;
            if (we) regs[idx] <= pwdata;
        end
    end
endmodule
